// File: rtl/ysyx_23060025_icache_assoc.sv
// ysyx_23060025_icache_assoc
//   N-way set-associative instruction cache between the IFU and an AXI read master.
//   Hits are served from the tag/data arrays. A miss refills the whole line with one
//   INCR burst into the chosen victim way. Fetches inside the uncached window skip the
//   arrays and use a single-beat read. fence.i clears every valid bit.
// Ports
//   clock, reset          : clock, synchronous active-high reset
//   in_paddr/in_psel      : fetch request (address held until in_pready)
//   in_pready/in_prdata   : one-cycle response pulse and instruction word
//   in_fence_flag/_done   : invalidate request and one-cycle completion pulse
//   out_ar*               : AXI read address channel
//   out_r*                : AXI read data channel
module ysyx_23060025_icache_assoc #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           WAYS       = 2,
    parameter int unsigned           SET_ADDR_W = 2,
    parameter int unsigned           LINE_OFF_W = 4,
    parameter logic [ADDR_WIDTH-1:0] UNC_BASE   = 32'h0F00_0000,
    parameter logic [ADDR_WIDTH-1:0] UNC_MASK   = 32'hFF00_0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    input  logic                  in_psel,
    output logic                  in_pready,
    output logic [31:0]           in_prdata,
    input  logic                  in_fence_flag,
    output logic                  in_fence_done,
    output logic [ADDR_WIDTH-1:0] out_araddr,
    output logic                  out_arvalid,
    input  logic                  out_arready,
    output logic [7:0]            out_arlen,
    output logic [2:0]            out_arsize,
    output logic [1:0]            out_arburst,
    input  logic                  out_rvalid,
    input  logic                  out_rlast,
    input  logic [31:0]           out_rdata,
    output logic                  out_rready
);

    localparam int unsigned SETS   = 1 << SET_ADDR_W;
    localparam int unsigned BEATS  = 1 << (LINE_OFF_W - 2);
    localparam int unsigned BEAT_W = (LINE_OFF_W > 2) ? (LINE_OFF_W - 2) : 1;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W  = ADDR_WIDTH - SET_ADDR_W - LINE_OFF_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_AR,
        S_LOAD,
        S_UPDATE,
        S_PASS,
        S_FENCE
    } state_t;

    state_t state_q, state_d;

    // Cache storage: valid bits and RR pointers are reset, tag/data arrays are not.
    logic [WAYS-1:0]  valid_q  [SETS];
    logic [WAY_W-1:0] rr_q     [SETS];
    logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
    logic [31:0]      data_mem [WAYS][SETS][BEATS];

    // Request captured in CHECK and held until the response.
    logic              unc_q;
    logic [TAG_W-1:0]  tag_r;
    logic [SET_ADDR_W-1:0] set_r;
    logic [BEAT_W-1:0] word_r;
    logic [WAY_W-1:0]  victim_r;
    logic [BEAT_W-1:0] beat_q;
    logic [31:0]       bypass_q;

    // Request address decode.
    logic [TAG_W-1:0]      req_tag;
    logic [SET_ADDR_W-1:0] req_set;
    logic [BEAT_W-1:0]     req_word;
    logic                  req_unc;

    assign req_tag  = in_paddr[ADDR_WIDTH-1 -: TAG_W];
    assign req_set  = in_paddr[LINE_OFF_W +: SET_ADDR_W];
    assign req_word = in_paddr[2 +: BEAT_W];
    assign req_unc  = (in_paddr & UNC_MASK) == UNC_BASE;

    assign out_arsize  = 3'b010;
    assign out_arburst = 2'b01;

    // Parallel tag compare across all ways of the addressed set.
    logic [WAYS-1:0]  hit_vec;
    logic             hit;
    logic [WAY_W-1:0] hit_way;

    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[req_set][w] && (tag_mem[w][req_set] == req_tag)) begin
                hit_vec[w] = 1'b1;
                hit        = 1'b1;
                hit_way    = WAY_W'(w);
            end
        end
    end

    // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
    logic [WAY_W-1:0] victim;
    logic             found_free;

    always_comb begin
        victim     = rr_q[req_set];
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!found_free && !valid_q[req_set][w]) begin
                victim     = WAY_W'(w);
                found_free = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_psel) begin
                    state_d = S_CHECK;
                end else if (in_fence_flag) begin
                    state_d = S_FENCE;
                end
            end
            S_CHECK:  state_d = (req_unc || !hit) ? S_AR : S_PASS;
            S_AR:     if (out_arready) state_d = S_LOAD;
            S_LOAD:   if (out_rvalid && out_rlast) state_d = S_UPDATE;
            S_UPDATE: state_d = S_PASS;
            S_PASS:   state_d = in_psel ? S_CHECK : S_IDLE;
            S_FENCE:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Registered outputs, request capture, valid bits and RR pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            beat_q        <= '0;
            in_pready     <= 1'b0;
            in_fence_done <= 1'b0;
            out_arvalid   <= 1'b0;
            out_rready    <= 1'b0;
            out_araddr    <= '0;
            out_arlen     <= '0;
            in_prdata     <= '0;
            unc_q         <= 1'b0;
            tag_r         <= '0;
            set_r         <= '0;
            word_r        <= '0;
            victim_r      <= '0;
            bypass_q      <= '0;
        end else begin
            in_pready     <= (state_d == S_PASS);
            in_fence_done <= (state_d == S_FENCE);
            out_arvalid   <= (state_d == S_AR);
            out_rready    <= (state_d == S_LOAD);
            case (state_q)
                S_CHECK: begin
                    unc_q    <= req_unc;
                    tag_r    <= req_tag;
                    set_r    <= req_set;
                    word_r   <= req_word;
                    victim_r <= victim;
                    if (req_unc) begin
                        out_araddr <= in_paddr;
                        out_arlen  <= 8'd0;
                    end else begin
                        out_araddr <= {req_tag, req_set, LINE_OFF_W'(0)};
                        out_arlen  <= 8'(BEATS - 1);
                    end
                    if (!req_unc && hit) begin
                        in_prdata <= data_mem[hit_way][req_set][req_word];
                    end
                end
                S_LOAD: begin
                    if (out_rvalid) begin
                        if (unc_q) begin
                            bypass_q <= out_rdata;
                        end
                        beat_q <= out_rlast ? '0 : BEAT_W'(beat_q + 1'b1);
                    end
                end
                S_UPDATE: begin
                    if (!unc_q) begin
                        valid_q[set_r][victim_r] <= 1'b1;
                        rr_q[set_r] <= WAY_W'((32'(rr_q[set_r]) + 32'd1) % WAYS);
                    end
                    in_prdata <= unc_q ? bypass_q : data_mem[victim_r][set_r][word_r];
                end
                S_FENCE: begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_q[s] <= '0;
                        rr_q[s]    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays; refill beats go straight into the victim way's line.
    always_ff @(posedge clock) begin
        if (state_q == S_LOAD && out_rvalid && !unc_q) begin
            data_mem[victim_r][set_r][beat_q] <= out_rdata;
        end
        if (state_q == S_UPDATE && !unc_q) begin
            tag_mem[victim_r][set_r] <= tag_r;
        end
    end

    // Design-error checks: multi-way hit, misplaced rlast, misaligned fetch.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == S_CHECK && !req_unc) begin
                assert ($onehot0(hit_vec));
            end
            if (state_q == S_LOAD && out_rvalid && out_rlast) begin
                assert (beat_q == (unc_q ? '0 : BEAT_W'(BEATS - 1)));
            end
            if (in_psel) begin
                assert (in_paddr[1:0] == 2'b00);
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_icache_assoc.sv
// Self-checking bench for ysyx_23060025_icache_assoc: directed scenarios plus a
// randomized fetch/fence mix against a set/way reference model and an AXI slave model.
module tb_ysyx_23060025_icache_assoc;

    localparam int unsigned WAYS  = 2;
    localparam int unsigned SETS  = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr;
    logic        in_psel;
    logic        in_pready;
    logic [31:0] in_prdata;
    logic        in_fence_flag;
    logic        in_fence_done;
    logic [31:0] out_araddr;
    logic        out_arvalid;
    logic        out_arready;
    logic [7:0]  out_arlen;
    logic [2:0]  out_arsize;
    logic [1:0]  out_arburst;
    logic        out_rvalid;
    logic        out_rlast;
    logic [31:0] out_rdata;
    logic        out_rready;

    always #5 clock = ~clock;

    ysyx_23060025_icache_assoc dut (
        .clock         (clock),
        .reset         (reset),
        .in_paddr      (in_paddr),
        .in_psel       (in_psel),
        .in_pready     (in_pready),
        .in_prdata     (in_prdata),
        .in_fence_flag (in_fence_flag),
        .in_fence_done (in_fence_done),
        .out_araddr    (out_araddr),
        .out_arvalid   (out_arvalid),
        .out_arready   (out_arready),
        .out_arlen     (out_arlen),
        .out_arsize    (out_arsize),
        .out_arburst   (out_arburst),
        .out_rvalid    (out_rvalid),
        .out_rlast     (out_rlast),
        .out_rdata     (out_rdata),
        .out_rready    (out_rready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", t, got, exp);
        end
    endtask

    logic [31:0] salt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ salt;
    endfunction

    // Reference model: per set, which tags occupy which ways, plus RR pointer.
    bit          mvalid [SETS][WAYS];
    logic [25:0] mtag   [SETS][WAYS];
    int          mrr    [SETS];

    function automatic void model_clear();
        for (int s = 0; s < SETS; s++) begin
            mrr[s] = 0;
            for (int w = 0; w < WAYS; w++) mvalid[s][w] = 0;
        end
    endfunction

    // AXI slave model, driven on the falling edge.
    int          ar_cnt     = 0;
    int          force_wait = -1;
    bit          rand_gaps  = 0;
    bit          s_pend     = 0;
    bit          ar_seen    = 0;
    int          s_beat     = 0;
    int          s_len      = 0;
    int          ar_wait    = 0;
    logic [31:0] s_addr;
    logic [31:0] last_araddr;
    logic [7:0]  last_arlen;

    initial begin
        out_arready = 1'b0;
        out_rvalid  = 1'b0;
        out_rlast   = 1'b0;
        out_rdata   = '0;
        forever begin
            @(negedge clock);
            out_arready = 1'b0;
            out_rvalid  = 1'b0;
            out_rlast   = 1'b0;
            if (reset) begin
                s_pend  = 0;
                ar_seen = 0;
            end else if (!s_pend && out_arvalid) begin
                if (!ar_seen) begin
                    ar_seen = 1;
                    s_addr  = out_araddr;
                    s_len   = int'(out_arlen);
                    ar_wait = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
                    force_wait = -1;
                end else begin
                    check("ar_hold_addr", out_araddr, s_addr);
                    check("ar_hold_len", 32'(out_arlen), 32'(s_len));
                end
                if (ar_wait > 0) begin
                    ar_wait--;
                end else begin
                    out_arready = 1'b1;
                    s_pend      = 1;
                    ar_seen     = 0;
                    s_beat      = 0;
                    ar_cnt++;
                    last_araddr = s_addr;
                    last_arlen  = 8'(s_len);
                end
            end else if (!s_pend && ar_seen && !out_arvalid) begin
                check("ar_hold_valid", 32'(out_arvalid), 32'd1);
                ar_seen = 0;
            end else if (s_pend && out_rready) begin
                if (!(rand_gaps && $urandom_range(0, 3) == 0)) begin
                    out_rvalid = 1'b1;
                    out_rdata  = mem_word(s_addr + 32'(4 * s_beat));
                    out_rlast  = (s_beat == s_len);
                    if (s_beat == s_len) s_pend = 0;
                    s_beat++;
                end
            end
        end
    end

    int fd_cnt = 0;
    always @(negedge clock) if (in_fence_done) fd_cnt++;

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    // One fetch: predicts hit/miss from the model, checks data, latency and AR.
    task automatic fetch(input logic [31:0] a, output bit hit_obs);
        int          c0;
        int          lat;
        bit          unc;
        int          set;
        logic [25:0] tg;
        bit          mhit;
        int          v;
        c0   = ar_cnt;
        unc  = (a & 32'hFF00_0000) == 32'h0F00_0000;
        set  = int'((a >> 4) & 32'h3);
        tg   = a[31:6];
        mhit = 0;
        if (!unc) for (int w = 0; w < WAYS; w++) if (mvalid[set][w] && mtag[set][w] == tg) mhit = 1;
        in_paddr = a;
        in_psel  = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!in_pready && lat < 300);
        in_psel = 1'b0;
        hit_obs = 0;
        if (!in_pready) begin
            check("fetch_timeout", 32'd0, 32'd1);
            return;
        end
        check("prdata", in_prdata, mem_word(a));
        hit_obs = (ar_cnt == c0);
        check("hit_vs_model", 32'(hit_obs), 32'(mhit));
        if (mhit) begin
            check("hit_latency", 32'(lat), 32'd2);
        end else begin
            check("ar_count", 32'(ar_cnt - c0), 32'd1);
            check("araddr", last_araddr, unc ? a : {a[31:4], 4'h0});
            check("arlen", 32'(last_arlen), unc ? 32'd0 : 32'd3);
        end
        tick();
        check("pready_pulse", 32'(in_pready), 32'd0);
        if (!mhit && !unc) begin
            v = mrr[set];
            for (int w = WAYS - 1; w >= 0; w--) if (!mvalid[set][w]) v = w;
            mvalid[set][v] = 1;
            mtag[set][v]   = tg;
            mrr[set]       = (mrr[set] + 1) % WAYS;
        end
    endtask

    task automatic fence_wait();
        int n;
        int f0;
        f0 = fd_cnt;
        n  = 0;
        in_fence_flag = 1'b1;
        do begin
            tick();
            n++;
        end while (!in_fence_done && n < 50);
        check("fence_done", 32'(in_fence_done), 32'd1);
        in_fence_flag = 1'b0;
        tick();
        check("fence_pulse", 32'(in_fence_done), 32'd0);
        check("fence_count", 32'(fd_cnt - f0), 32'd1);
        model_clear();
    endtask

    initial begin
        bit          h;
        int          n;
        int          f0;
        int          r;
        logic [31:0] a;
        salt          = $urandom;
        reset         = 1'b1;
        in_psel       = 1'b0;
        in_paddr      = '0;
        in_fence_flag = 1'b0;
        model_clear();
        repeat (3) tick();
        check("rst_pready", 32'(in_pready), 32'd0);
        check("rst_fence_done", 32'(in_fence_done), 32'd0);
        check("rst_arvalid", 32'(out_arvalid), 32'd0);
        check("rst_rready", 32'(out_rready), 32'd0);
        reset = 1'b0;
        tick();
        check("arsize", 32'(out_arsize), 32'd2);
        check("arburst", 32'(out_arburst), 32'd1);

        // Cold miss then hit in the same line.
        fetch(32'h3000_0010, h);
        check("t1_cold_miss", 32'(h), 32'd0);
        check("t1_araddr", last_araddr, 32'h3000_0010);
        fetch(32'h3000_0014, h);
        check("t1_rehit", 32'(h), 32'd1);

        // Two-way conflict in set 0 with round-robin eviction.
        fetch(32'h3000_0000, h);
        fetch(32'h3000_0040, h);
        fetch(32'h3000_0000, h);
        check("t2_hit_a", 32'(h), 32'd1);
        fetch(32'h3000_0044, h);
        check("t2_hit_b", 32'(h), 32'd1);
        fetch(32'h3000_0080, h);
        check("t2_miss_c", 32'(h), 32'd0);
        fetch(32'h3000_0048, h);
        check("t2_b_kept", 32'(h), 32'd1);
        fetch(32'h3000_0000, h);
        check("t2_a_evicted", 32'(h), 32'd0);

        // Uncached window is never cached.
        fetch(32'h0F00_0008, h);
        check("t3_unc_first", 32'(h), 32'd0);
        check("t3_unc_addr", last_araddr, 32'h0F00_0008);
        fetch(32'h0F00_0008, h);
        check("t3_unc_again", 32'(h), 32'd0);

        // Fence invalidates.
        fetch(32'h3000_0000, h);
        fence_wait();
        fetch(32'h3000_0000, h);
        check("t4_post_fence_miss", 32'(h), 32'd0);

        // Fetch wins over a simultaneous fence; then a held-off AR.
        f0 = fd_cnt;
        in_fence_flag = 1'b1;
        fetch(32'h3000_0004, h);
        check("t5_fetch_first_hit", 32'(h), 32'd1);
        check("t5_no_fence_yet", 32'(fd_cnt - f0), 32'd0);
        fence_wait();
        force_wait = 5;
        fetch(32'h3000_0000, h);
        check("t5_stall_miss", 32'(h), 32'd0);

        // Reset during refill beat 2.
        rand_gaps = 0;
        in_paddr  = 32'h3000_0020;
        in_psel   = 1'b1;
        n = 0;
        while (!(s_pend && s_beat == 3) && n < 100) begin
            tick();
            n++;
        end
        check("t6_reached_beat2", 32'(s_beat), 32'd3);
        reset   = 1'b1;
        in_psel = 1'b0;
        tick();
        check("t6_arvalid", 32'(out_arvalid), 32'd0);
        check("t6_rready", 32'(out_rready), 32'd0);
        check("t6_pready", 32'(in_pready), 32'd0);
        reset = 1'b0;
        model_clear();
        tick();
        fetch(32'h3000_0020, h);
        check("t6_post_reset_miss", 32'(h), 32'd0);

        // Randomized mix.
        rand_gaps = 1;
        repeat (200) begin
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                fence_wait();
            end else begin
                if (r < 15) a = 32'h0F00_0000 + 32'($urandom_range(0, 63)) * 32'd4;
                else a = 32'h3000_0000 + (32'($urandom_range(0, 5)) << 6)
                       + (32'($urandom_range(0, 3)) << 4) + (32'($urandom_range(0, 3)) << 2);
                fetch(a, h);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
